// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset core, with memory timeout
// and a retired-instruction counter. Define ILLEGAL_TRAP_EN to trap on unknown opcodes.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             branch,
    output logic             bne,
    output logic             jump,
    output logic             instr_check,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired,
`ifdef ILLEGAL_TRAP_EN
    output logic             trap,
`endif
    output logic [2:0]       state_o
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       bne;
        logic       jump;
    } strobes_t;

    state_t            r_state;
    state_t            w_next;
    logic [5:0]        r_opcode;
    logic              r_instr_check;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_retired;
    strobes_t          w_strb;
    logic              w_wait_state;
    logic              w_timeout;
    logic              w_retire;
    logic              w_unused_instr;

    assign w_unused_instr = ^instr[25:0];

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout    = w_wait_state && !mem_ready
                          && (r_wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        w_strb = '0;
        case (r_state)
            S_FETCH: begin
                w_strb.mem_read = 1'b1;
                if (mem_ready) begin
                    w_strb.ir_write = 1'b1;
                    w_strb.pc_write = 1'b1;
                    w_next          = S_DECODE;
                end
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                case (instr[31:26])
                    OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ANDI, OP_LW, OP_SW: w_next = S_EXEC;
                    default:                        w_next = S_TRAP;
                endcase
`else
                w_next = S_EXEC;
`endif
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (r_opcode)
                    OP_RTYPE: begin
                        w_strb.alu_op = 2'b10;
                        w_next        = S_WB;
                    end
                    OP_ADDI: begin
                        w_strb.alu_src = 1'b1;
                        w_next         = S_WB;
                    end
                    OP_ANDI: begin
                        w_strb.alu_op  = 2'b11;
                        w_strb.alu_src = 1'b1;
                        w_next         = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        w_strb.alu_src = 1'b1;
                        w_next         = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        w_strb.branch        = 1'b1;
                        w_strb.pc_write_cond = 1'b1;
                        w_strb.alu_op        = 2'b01;
                        w_strb.bne           = (r_opcode == OP_BNE);
                    end
                    OP_J: begin
                        w_strb.jump     = 1'b1;
                        w_strb.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (r_opcode == OP_LW) begin
                    w_strb.mem_read = 1'b1;
                    if (mem_ready) w_next = S_WB;
                end else begin
                    w_strb.mem_write = 1'b1;
                    if (mem_ready) w_next = S_FETCH;
                end
            end
            S_WB: begin
                w_strb.reg_write  = 1'b1;
                w_strb.mem_to_reg = (r_opcode == OP_LW);
                w_next            = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
        if (w_timeout) begin
            w_next = S_FETCH;
        end
    end

    // A timeout abandons the instruction, so it must not count as a retirement out of MEM.
    assign w_retire = (w_next == S_FETCH) && !w_timeout
                      && ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_opcode      <= '0;
            r_instr_check <= 1'b0;
            r_wait_cnt    <= '0;
            r_retired     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode      <= instr[31:26];
                r_instr_check <= (instr[31:26] != OP_RTYPE);
            end
            if ((w_next != r_state) || mem_ready || w_timeout) begin
                r_wait_cnt <= '0;
            end else if (w_wait_state) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Strobes are also gated by rst_n so nothing stays asserted while reset is held.
    assign {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
            mem_to_reg, alu_src, alu_op, branch, bne, jump} =
           (rst_n && !w_timeout) ? w_strb : '0;

    assign bus_err     = rst_n && w_timeout;
    assign instr_check = r_instr_check;
    assign retired     = r_retired;
    assign state_o     = r_state;
`ifdef ILLEGAL_TRAP_EN
    assign trap        = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state sequencing, strobes, memory waits,
// timeout, mid-instruction reset and unknown-opcode handling (with/without ILLEGAL_TRAP_EN).
module tb_multicycle_control;

    localparam logic [31:0] I_R    = 32'h0000_0020;
    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_BNE  = 32'h1400_0000;
    localparam logic [31:0] I_ANDI = 32'h3000_0000;
    localparam logic [31:0] I_J    = 32'h0800_0000;
    localparam logic [31:0] I_ADDI = 32'h2000_0000;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    // {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src, alu_op, branch, bne, jump}
    localparam logic [12:0] S_NONE   = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [12:0] S_FETCH  = 13'b1_0_1_1_0_0_0_0_00_0_0_0;
    localparam logic [12:0] S_EX_R   = 13'b0_0_0_0_0_0_0_0_10_0_0_0;
    localparam logic [12:0] S_EX_IMM = 13'b0_0_0_0_0_0_0_1_00_0_0_0;
    localparam logic [12:0] S_EX_AND = 13'b0_0_0_0_0_0_0_1_11_0_0_0;
    localparam logic [12:0] S_EX_BNE = 13'b0_1_0_0_0_0_0_0_01_1_1_0;
    localparam logic [12:0] S_EX_J   = 13'b1_0_0_0_0_0_0_0_00_0_0_1;
    localparam logic [12:0] S_MEM_RD = 13'b0_0_0_1_0_0_0_0_00_0_0_0;
    localparam logic [12:0] S_WB_ALU = 13'b0_0_0_0_0_1_0_0_00_0_0_0;
    localparam logic [12:0] S_WB_LW  = 13'b0_0_0_0_0_1_1_0_00_0_0_0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
    logic        mem_to_reg, alu_src, branch, bne, jump, instr_check, bus_err;
    logic [1:0]  alu_op;
    logic [31:0] retired;
    logic [2:0]  state_o;
`ifdef ILLEGAL_TRAP_EN
    logic        trap;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    multicycle_control #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
        .branch(branch), .bne(bne), .jump(jump), .instr_check(instr_check),
        .bus_err(bus_err), .retired(retired),
`ifdef ILLEGAL_TRAP_EN
        .trap(trap),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] strobes();
        return {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
                mem_to_reg, alu_src, alu_op, branch, bne, jump};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs FETCH (zero-wait) and DECODE, leaving the DUT in EXEC.
    task automatic fetch_decode(input logic [31:0] iw, input string tag);
        instr     = iw;
        mem_ready = 1'b1;
        #1;
        check({tag, "_fetch_state"}, 64'(state_o), 64'd0);
        check({tag, "_fetch_strb"}, 64'(strobes()), 64'(S_FETCH));
        tick();
        check({tag, "_decode_state"}, 64'(state_o), 64'd1);
        check({tag, "_decode_strb"}, 64'(strobes()), 64'(S_NONE));
        tick();
    endtask

    initial begin
        int start;
        int n_mw;
        int n_err;
        int err_at;
        int n_irw;
        logic rd_at_err;

        rst_n = 1'b0;
        mem_ready = 1'b0;
        instr = '0;
        tick();
        tick();
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_icheck", 64'(instr_check), 64'd0);
        check("rst_strb", 64'(strobes()), 64'(S_NONE));
        check("rst_buserr", 64'(bus_err), 64'd0);
        rst_n = 1'b1;

        // R-type: 0,1,2,4
        fetch_decode(I_R, "r");
        check("r_exec_state", 64'(state_o), 64'd2);
        check("r_exec_strb", 64'(strobes()), 64'(S_EX_R));
        tick();
        check("r_wb_state", 64'(state_o), 64'd4);
        check("r_wb_strb", 64'(strobes()), 64'(S_WB_ALU));
        tick();
        check("r_retired", 64'(retired), 64'd1);
        check("r_icheck", 64'(instr_check), 64'd0);

        // lw: 0,1,2,3,4
        fetch_decode(I_LW, "lw");
        check("lw_exec_strb", 64'(strobes()), 64'(S_EX_IMM));
        tick();
        check("lw_mem_state", 64'(state_o), 64'd3);
        check("lw_mem_strb", 64'(strobes()), 64'(S_MEM_RD));
        tick();
        check("lw_wb_state", 64'(state_o), 64'd4);
        check("lw_wb_strb", 64'(strobes()), 64'(S_WB_LW));
        tick();
        check("lw_done_state", 64'(state_o), 64'd0);
        check("lw_retired", 64'(retired), 64'd2);
        check("lw_icheck", 64'(instr_check), 64'd1);

        fetch_decode(I_BNE, "bne");
        check("bne_exec_strb", 64'(strobes()), 64'(S_EX_BNE));
        tick();
        check("bne_next_state", 64'(state_o), 64'd0);
        check("bne_retired", 64'(retired), 64'd3);

        fetch_decode(I_ANDI, "andi");
        check("andi_exec_strb", 64'(strobes()), 64'(S_EX_AND));
        tick();
        check("andi_wb_strb", 64'(strobes()), 64'(S_WB_ALU));
        tick();
        check("andi_retired", 64'(retired), 64'd4);

        fetch_decode(I_J, "j");
        check("j_exec_strb", 64'(strobes()), 64'(S_EX_J));
        tick();
        check("j_next_state", 64'(state_o), 64'd0);
        check("j_retired", 64'(retired), 64'd5);

        // sw with 3 wait cycles in MEM: 7 cycles, mem_write for 4
        start = cyc;
        n_mw = 0;
        n_err = 0;
        fetch_decode(I_SW, "sw");
        check("sw_exec_strb", 64'(strobes()), 64'(S_EX_IMM));
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            if (mem_write) n_mw++;
            if (bus_err) n_err++;
            tick();
        end
        check("sw_memwrite_cycles", 64'(n_mw), 64'd4);
        check("sw_total_cycles", 64'(cyc - start), 64'd7);
        check("sw_buserr", 64'(n_err), 64'd0);
        check("sw_done_state", 64'(state_o), 64'd0);
        check("sw_retired", 64'(retired), 64'd6);

        // Timeout in FETCH: bus_err on the 16th waiting cycle
        mem_ready = 1'b0;
        n_err = 0;
        err_at = 0;
        n_irw = 0;
        rd_at_err = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (bus_err) begin
                n_err++;
                if (err_at == 0) begin
                    err_at = i;
                    rd_at_err = mem_read;
                end
            end
            if (ir_write) n_irw++;
            if (i == 16) begin
                tick();
                break;
            end
            tick();
        end
        check("to_pulses", 64'(n_err), 64'd1);
        check("to_cycle", 64'(err_at), 64'd16);
        check("to_memread_gated", 64'(rd_at_err), 64'd0);
        check("to_irwrite", 64'(n_irw), 64'd0);
        check("to_state", 64'(state_o), 64'd0);
        check("to_retired", 64'(retired), 64'd6);

        // mem_ready arriving in the would-be timeout cycle completes normally
        n_err = 0;
        for (int i = 1; i <= 15; i++) begin
            #1;
            if (bus_err) n_err++;
            tick();
        end
        check("late_ready_noerr_wait", 64'(n_err), 64'd0);
        instr = I_ADDI;
        mem_ready = 1'b1;
        #1;
        check("late_ready_buserr", 64'(bus_err), 64'd0);
        check("late_ready_strb", 64'(strobes()), 64'(S_FETCH));
        tick();
        check("addi_decode_state", 64'(state_o), 64'd1);
        tick();
        check("addi_exec_strb", 64'(strobes()), 64'(S_EX_IMM));
        tick();
        check("addi_wb_regwrite", 64'(reg_write), 64'd1);

        // Reset during addi WB
        rst_n = 1'b0;
        #1;
        check("midrst_regwrite", 64'(reg_write), 64'd0);
        check("midrst_state", 64'(state_o), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("midrst_retired", 64'(retired), 64'd0);

        fetch_decode(I_BAD, "bad");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            check("trap_state", 64'(state_o), 64'd5);
            check("trap_flag", 64'(trap), 64'd1);
            check("trap_strb", 64'(strobes()), 64'(S_NONE));
            tick();
        end
        check("trap_retired", 64'(retired), 64'd0);
        rst_n = 1'b0;
        #1;
        check("trap_rst_state", 64'(state_o), 64'd0);
        check("trap_rst_flag", 64'(trap), 64'd0);
        rst_n = 1'b1;
`else
        check("bad_exec_state", 64'(state_o), 64'd2);
        check("bad_exec_strb", 64'(strobes()), 64'(S_NONE));
        tick();
        check("bad_next_state", 64'(state_o), 64'd0);
        check("bad_retired", 64'(retired), 64'd1);
        check("bad_icheck", 64'(instr_check), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-subset core: R-type, j, andi, sw, lw, addi, beq, bne.
- Replaces the per-instruction combinational decode with a FETCH/DECODE/EXEC/MEM/WB state machine.
- Handles memory wait states and memory timeout.
- Counts retired instructions.
- Drives the shared-memory datapath: PC, IR, ALU, register file and data memory.

Parameters:
- TIMEOUT, 16: max cycles waiting for mem_ready before abort; must be ≥2.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  IR contents; opcode = instr[31:26].
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load gated by the datapath branch compare.
- ir_write  out  1  IR load.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source is memory data.
- alu_src  out  1  ALU B operand is the immediate.
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 funct, 11 and.
- branch  out  1  branch instruction in EXEC.
- bne  out  1  invert the compare (bne).
- jump  out  1  PC source is the jump target.
- instr_check  out  1  1 for any non-R-type opcode, registered at DECODE.
- bus_err  out  1  one-cycle pulse on memory timeout.
- retired  out  CNT_W  count of completed instructions.
- state_o  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Behaviour:
- Reset (asynchronous): state=FETCH; retired=0; instr_check=0; wait counter=0; trap=0; all strobes deasserted.
- Strobes are Moore/Mealy combinational from the state, the registered opcode and mem_ready.
- Any strobe not named for a state is 0 in that state.
- FETCH:
  - mem_read=1.
  - On mem_ready: ir_write=1, pc_write=1 (PC+4), alu_op=00, go to DECODE.
  - Otherwise hold in FETCH.
- DECODE:
  - One cycle; latch instr[31:26] into the opcode register; set instr_check.
  - Go to EXEC.
- EXEC:
  - R-type: alu_op=10, alu_src=0, go to WB.
  - addi: alu_op=00, alu_src=1, go to WB.
  - andi: alu_op=11, alu_src=1, go to WB.
  - lw/sw: alu_op=00, alu_src=1, go to MEM.
  - beq: branch=1, pc_write_cond=1, alu_op=01, go to FETCH.
  - bne: as beq, plus bne=1.
  - j: jump=1, pc_write=1, go to FETCH.
  - Unknown opcode: no strobes, go to FETCH.
- MEM:
  - lw: mem_read=1; on mem_ready go to WB.
  - sw: mem_write=1; on mem_ready go to FETCH.
- WB:
  - reg_write=1; mem_to_reg=1 only for lw.
  - Go to FETCH.
- Latency with zero-wait memory (mem_ready already high):
  - 3 cycles: j, beq, bne, unknown.
  - 4 cycles: R-type, addi, andi, sw.
  - 5 cycles: lw.
  - Each wait cycle adds one.
- Retire:
  - retired increments by 1 on every transition into FETCH from EXEC, MEM or WB.
  - Wraps modulo 2^CNT_W.
- Timeout:
  - Wait counter increments each cycle in FETCH or MEM with mem_ready=0.
  - Cleared on mem_ready or on any state change.
  - When the counter reaches TIMEOUT-1 with mem_ready still 0: bus_err=1 for that cycle, all strobes forced 0, go to FETCH (instruction abandoned, not retired, PC not advanced).
  - mem_ready=1 in the timeout cycle wins: normal completion, no bus_err.
- Reset mid-operation: immediate return to FETCH; a partially executed instruction is not retired and no strobe is held.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port trap (1 bit).
  - An unknown opcode in DECODE goes to TRAP instead of EXEC.
  - TRAP asserts trap=1 and holds all strobes 0 until reset; retired is frozen.
- Undefined:
  - No trap port; TRAP is unreachable.
  - Unknown opcodes execute as 3-cycle NOPs and are retired.

Test Plan:
- Reset with rst_n=0 mid-WB of an addi -> reg_write drops the same cycle; state_o=0, retired=0 after release.
- mem_ready tied 1, R-type then lw (opcode 6'b100011) -> state_o sequences 0,1,2,4 then 0,1,2,3,4; reg_write and mem_to_reg=1 in lw WB only; retired=2.
- bne (6'b000101) -> exactly one EXEC cycle with branch=1, bne=1, pc_write_cond=1, alu_op=01; then FETCH.
- sw with mem_ready low for 3 cycles in MEM -> mem_write high 4 cycles; 7 cycles total; no bus_err.
- TIMEOUT=16, mem_ready held 0 in FETCH -> bus_err pulses on the 16th cycle; state_o=0; retired unchanged; no ir_write.
- Opcode 6'b111111 -> with ILLEGAL_TRAP_EN: trap=1 and state_o=5 stuck until reset. Without it: 3-cycle NOP, retired+1.
